// File: rtl/inst_fetch_resp_pkg.sv
// Shared constants for the instruction fetch responder: enable and branch
// encodings, default widths, buffer depth and the NOP word used by the
// optional alignment check (FETCH_ALIGN_CHK_EN).
package inst_fetch_resp_pkg;

    localparam logic FETCH_EN     = 1'b1;
    localparam logic BRANCH_TAKEN = 1'b1;

    localparam int FETCH_ADDR_W     = 32;
    localparam int FETCH_DATA_W     = 32;
    localparam int FETCH_FIFO_DEPTH = 2;

    localparam logic [31:0] FETCH_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_resp_fetch_fifo.sv
// Synchronous FIFO for fetched words: push, pop, clear, count, empty, full.
// Head word is read straight out of the storage flops. DEPTH is a power of
// two, so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next-state storage, pointers and count; clear wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage register.
    // NOTE: storage is deliberately not reset; count/empty decide whether its contents mean anything.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: issues PC reads to a 1-cycle synchronous
// instruction memory, tags returned words with their PC, buffers them and
// hands them to decode over valid/ready. Back-pressures the PC generator
// with a registered stall and squashes everything on a branch flush.
// Optional: FETCH_ALIGN_CHK_EN replaces misaligned fetches with NOP_INST
// and flags them on inst_misalign_o.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int ADDR_W     = FETCH_ADDR_W,
    parameter int DATA_W     = FETCH_DATA_W,
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
`ifdef FETCH_ALIGN_CHK_EN
    ,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(FETCH_NOP_INST)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_misalign_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
`ifdef FETCH_ALIGN_CHK_EN
    localparam int FLAG_W = 1;
`else
    localparam int FLAG_W = 0;
`endif
    localparam int ENTRY_W = FLAG_W + ADDR_W + DATA_W;

    logic               issue, push, pop;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  tag_q, tag_d;
    logic               stall_q, stall_d;
    logic [CNT_W-1:0]   count_next;
    logic [OCC_W-1:0]   occ_next;
    logic [ENTRY_W-1:0] entry_in, entry_out;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty, fifo_full;
`ifdef FETCH_ALIGN_CHK_EN
    logic               mis_q, mis_d;
`endif

    // Request side: decide whether pc_i is accepted this cycle.
    always_comb begin
        issue      = (ce_i == FETCH_EN) && (flush_i != BRANCH_TAKEN) && !stall_q && !rst;
        mem_addr_o = pc_i;
`ifdef FETCH_ALIGN_CHK_EN
        mis_d      = issue && (pc_i[1:0] != 2'b00);
        mem_en_o   = issue && !mis_d;
`else
        mem_en_o   = issue;
`endif
        inflight_d = issue;
        tag_d      = issue ? pc_i : tag_q;
    end

    // Response side: push the returning word unless flushed; predict the
    // next occupancy so stall can be registered without glitches.
    always_comb begin
        push = inflight_q && (flush_i != BRANCH_TAKEN);
        pop  = inst_valid_o && inst_ready_i;
`ifdef FETCH_ALIGN_CHK_EN
        entry_in = {mis_q, tag_q, mis_q ? NOP_INST : mem_data_i};
`else
        entry_in = {tag_q, mem_data_i};
`endif
        count_next = fifo_count + CNT_W'(push && (!fifo_full || pop)) - CNT_W'(pop);
        if (flush_i == BRANCH_TAKEN) begin
            count_next = '0;
        end
        occ_next = OCC_W'(count_next) + OCC_W'(inflight_d);
        stall_d  = (occ_next >= OCC_W'(FIFO_DEPTH));
    end

    // Inflight tracking and stall register.
    // NOTE: sequential state uses non-blocking assignments only; the blocking forms live in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
            stall_q    <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            stall_q    <= stall_d;
`ifdef FETCH_ALIGN_CHK_EN
            mis_q      <= mis_d;
`endif
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (entry_in),
        .pop_i   (pop),
        .clear_i (flush_i == BRANCH_TAKEN),
        .data_o  (entry_out),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Decode-facing outputs: FIFO head, forced to zero while empty.
    always_comb begin
        stall_o      = stall_q;
        inst_valid_o = (fifo_count != '0);
        inst_o       = fifo_empty ? '0 : entry_out[DATA_W-1:0];
        inst_pc_o    = fifo_empty ? '0 : entry_out[ADDR_W+DATA_W-1:DATA_W];
`ifdef FETCH_ALIGN_CHK_EN
        inst_misalign_o = !fifo_empty && entry_out[ENTRY_W-1];
`else
        inst_misalign_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Self-checking bench for inst_fetch_resp: scoreboard of expected
// {pc, data, misalign} pushed when a fetch is accepted, popped by a
// monitor on every decode handshake.
module tb_inst_fetch_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        stall_o;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i = 32'hDEAD_BEEF;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_misalign_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    inst_fetch_resp dut (
        .clk             (clk),
        .rst             (rst),
        .ce_i            (ce_i),
        .pc_i            (pc_i),
        .flush_i         (flush_i),
        .stall_o         (stall_o),
        .mem_en_o        (mem_en_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_i      (mem_data_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_misalign_o (inst_misalign_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory model: 1-cycle latency, garbage when not enabled.
    always @(posedge clk) mem_data_i <= mem_en_o ? (mem_addr_o ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

    function automatic exp_t mk(input logic [31:0] pc, input logic mis);
        exp_t e;
        e.pc   = pc;
        e.data = mis ? 32'h0000_0000 : (pc ^ 32'hA5A5_0000);
        e.mis  = mis;
        return e;
    endfunction

    // Handshake monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && inst_valid_o && inst_ready_i) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_word: got pc=%h data=%h, required no delivery", inst_pc_o, inst_o);
            end else begin
                e = sb_q.pop_front();
                if (inst_pc_o !== e.pc || inst_o !== e.data || inst_misalign_o !== e.mis)
                    $display("FAIL delivered_word: got pc=%h data=%h mis=%b, required pc=%h data=%h mis=%b",
                             inst_pc_o, inst_o, inst_misalign_o, e.pc, e.data, e.mis);
                else
                    passes++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic drain(input string name);
        int c = 0;
        @(negedge clk);
        ce_i = 1'b0; flush_i = 1'b0; inst_ready_i = 1'b1;
        while (c < 20 && (sb_q.size() != 0 || inst_valid_o)) begin
            @(negedge clk);
            c++;
        end
        #1;
        checks++;
        if (sb_q.size() != 0 || inst_valid_o !== 1'b0)
            $display("FAIL %s_drain: got %0d words outstanding valid=%b, required 0 and 0", name, sb_q.size(), inst_valid_o);
        else
            passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_i = 1'b1; pc_i = 32'h1234; flush_i = 1'b0; inst_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall_o, inst_valid_o, mem_en_o, inst_misalign_o} !== 4'b0000)
            $display("FAIL reset_flags: got stall/valid/mem_en/mis=%b%b%b%b, required 0000",
                     stall_o, inst_valid_o, mem_en_o, inst_misalign_o);
        else
            passes++;
        checks++;
        if (inst_o !== 32'h0 || inst_pc_o !== 32'h0)
            $display("FAIL reset_data: got inst=%h pc=%h, required 0 and 0", inst_o, inst_pc_o);
        else
            passes++;
        @(negedge clk);
        rst = 1'b0; ce_i = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        int idx = 0;
        int first_issue = -1;
        int first_valid = -1;
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        for (int c = 0; c < 30 && (idx < 3 || sb_q.size() != 0); c++) begin
            @(negedge clk);
            inst_ready_i = 1'b1;
            ce_i = (idx < 3);
            pc_i = (idx < 3) ? pcs[idx] : 32'h0;
            #1;
            if (first_valid < 0 && inst_valid_o) first_valid = cyc;
            if (c == 0) begin
                checks++;
                if (mem_en_o !== 1'b1) $display("FAIL stream_first_issue: got mem_en=%b, required 1", mem_en_o);
                else passes++;
            end
            if (mem_en_o && idx < 3) begin
                checks++;
                if (mem_addr_o !== pcs[idx]) $display("FAIL stream_addr: got %h, required %h", mem_addr_o, pcs[idx]);
                else passes++;
                if (first_issue < 0) first_issue = cyc;
                sb_q.push_back(mk(pcs[idx], 1'b0));
                idx++;
            end
        end
        ce_i = 1'b0;
        checks++;
        if (first_issue < 0 || first_valid - first_issue != 2)
            $display("FAIL stream_latency: got %0d cycles, required 2", first_valid - first_issue);
        else
            passes++;
        drain("stream");
    endtask

    task automatic test_back_pressure();
        int c;
        @(negedge clk);
        inst_ready_i = 1'b0; ce_i = 1'b1; pc_i = 32'h0;
        #1;
        checks++;
        if (mem_en_o !== 1'b1) $display("FAIL bp_issue0: got mem_en=%b, required 1", mem_en_o); else passes++;
        sb_q.push_back(mk(32'h0, 1'b0));
        @(negedge clk);
        pc_i = 32'h4;
        #1;
        checks++;
        if (mem_en_o !== 1'b1) $display("FAIL bp_issue4: got mem_en=%b, required 1", mem_en_o); else passes++;
        sb_q.push_back(mk(32'h4, 1'b0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pc_i = 32'h8;
            #1;
            checks++;
            if ({stall_o, mem_en_o, inst_valid_o} !== 3'b101 || inst_pc_o !== 32'h0)
                $display("FAIL bp_full: got stall/mem_en/valid=%b%b%b head=%h, required 101 head=00000000",
                         stall_o, mem_en_o, inst_valid_o, inst_pc_o);
            else
                passes++;
        end
        c = 0;
        @(negedge clk);
        inst_ready_i = 1'b1;
        #1;
        while (c < 10 && !mem_en_o) begin
            @(negedge clk);
            c++;
            #1;
        end
        checks++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h8)
            $display("FAIL bp_resume: got mem_en=%b addr=%h, required 1 and 00000008", mem_en_o, mem_addr_o);
        else
            passes++;
        if (mem_en_o) sb_q.push_back(mk(32'h8, 1'b0));
        drain("bp");
    endtask

    task automatic test_flush();
        @(negedge clk);
        inst_ready_i = 1'b0; ce_i = 1'b1; pc_i = 32'hC;
        @(negedge clk);
        pc_i = 32'h10;
        @(negedge clk);
        flush_i = 1'b1; pc_i = 32'h14;
        #1;
        checks++;
        if (mem_en_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_pc_o !== 32'hC)
            $display("FAIL flush_cycle: got mem_en=%b valid=%b head=%h, required 0 1 0000000c",
                     mem_en_o, inst_valid_o, inst_pc_o);
        else
            passes++;
        @(negedge clk);
        flush_i = 1'b0; pc_i = 32'h40; inst_ready_i = 1'b1;
        #1;
        checks++;
        if (inst_valid_o !== 1'b0 || stall_o !== 1'b0 || mem_en_o !== 1'b1)
            $display("FAIL flush_next: got valid=%b stall=%b mem_en=%b, required 0 0 1", inst_valid_o, stall_o, mem_en_o);
        else
            passes++;
        sb_q.push_back(mk(32'h40, 1'b0));
        @(negedge clk);
        ce_i = 1'b0;
        #1;
        checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL flush_dropped: got valid=%b, required 0", inst_valid_o); else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h40)
            $display("FAIL flush_target: got valid=%b pc=%h, required 1 00000040", inst_valid_o, inst_pc_o);
        else
            passes++;
        drain("flush");
    endtask

    task automatic test_ce_low();
        @(negedge clk);
        inst_ready_i = 1'b1; ce_i = 1'b1; pc_i = 32'h80;
        #1;
        checks++;
        if (mem_en_o !== 1'b1) $display("FAIL ce_issue: got mem_en=%b, required 1", mem_en_o); else passes++;
        sb_q.push_back(mk(32'h80, 1'b0));
        @(negedge clk);
        ce_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h80)
            $display("FAIL ce_deliver: got valid=%b pc=%h, required 1 00000080", inst_valid_o, inst_pc_o);
        else
            passes++;
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (inst_valid_o !== 1'b0 || mem_en_o !== 1'b0)
                $display("FAIL ce_idle: got valid=%b mem_en=%b, required 0 0", inst_valid_o, mem_en_o);
            else
                passes++;
        end
        drain("ce");
    endtask

    task automatic test_reset_full();
        @(negedge clk);
        inst_ready_i = 1'b0; ce_i = 1'b1; pc_i = 32'h100;
        @(negedge clk);
        pc_i = 32'h104;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (inst_valid_o !== 1'b1 || stall_o !== 1'b1)
            $display("FAIL rstf_full: got valid=%b stall=%b, required 1 1", inst_valid_o, stall_o);
        else
            passes++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ce_i = 1'b0;
        #1;
        checks++;
        if ({inst_valid_o, stall_o, mem_en_o, inst_misalign_o} !== 4'b0000 || inst_o !== 32'h0 || inst_pc_o !== 32'h0)
            $display("FAIL rstf_outputs: got valid/stall/mem_en/mis=%b%b%b%b inst=%h pc=%h, required 0000 0 0",
                     inst_valid_o, stall_o, mem_en_o, inst_misalign_o, inst_o, inst_pc_o);
        else
            passes++;
        @(negedge clk);
        inst_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL rstf_quiet: got valid=%b, required 0", inst_valid_o); else passes++;
    endtask

`ifdef FETCH_ALIGN_CHK_EN
    task automatic test_misalign();
        @(negedge clk);
        inst_ready_i = 1'b1; ce_i = 1'b1; pc_i = 32'h6;
        #1;
        checks++;
        if (mem_en_o !== 1'b0) $display("FAIL mis_no_mem: got mem_en=%b, required 0", mem_en_o); else passes++;
        sb_q.push_back(mk(32'h6, 1'b1));
        @(negedge clk);
        ce_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (inst_valid_o !== 1'b1 || inst_misalign_o !== 1'b1 || inst_o !== 32'h0 || inst_pc_o !== 32'h6)
            $display("FAIL mis_word: got valid=%b mis=%b inst=%h pc=%h, required 1 1 00000000 00000006",
                     inst_valid_o, inst_misalign_o, inst_o, inst_pc_o);
        else
            passes++;
        drain("mis");
    endtask
`endif

    initial begin
        rst = 1'b1; ce_i = 1'b0; pc_i = 32'h0; flush_i = 1'b0; inst_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_ce_low();
        test_reset_full();
`ifdef FETCH_ALIGN_CHK_EN
        test_misalign();
`endif
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
